// File: rtl/tc_sram_initiator.sv
// Requester-side adapter for one tc_sram port: valid/ready requests in, raw memory cycles out,
// read data tracked over the fixed memory latency and buffered in a credit-protected response FIFO.
module tc_sram_initiator #(
   parameter int unsigned NumWords  = 1024,
   parameter int unsigned DataWidth = 128,
   parameter int unsigned ByteWidth = 8,
   parameter int unsigned Latency   = 1,
   parameter int unsigned RspDepth  = 2,
   localparam int unsigned AddrWidth = (NumWords > 1) ? $clog2(NumWords) : 1,
   localparam int unsigned BeWidth   = (DataWidth + ByteWidth - 1) / ByteWidth
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 req_valid_i,
   output logic                 req_ready_o,
   input  logic                 req_we_i,
   input  logic [AddrWidth-1:0] req_addr_i,
   input  logic [DataWidth-1:0] req_wdata_i,
   input  logic [BeWidth-1:0]   req_be_i,
   output logic                 rsp_valid_o,
   input  logic                 rsp_ready_i,
   output logic [DataWidth-1:0] rsp_rdata_o,
   output logic                 mem_req_o,
   output logic                 mem_we_o,
   output logic [AddrWidth-1:0] mem_addr_o,
   output logic [DataWidth-1:0] mem_wdata_o,
   output logic [BeWidth-1:0]   mem_be_o,
   input  logic [DataWidth-1:0] mem_rdata_i
);

   localparam int unsigned CntW = $clog2(RspDepth + 1);
   localparam int unsigned PtrW = (RspDepth > 1) ? $clog2(RspDepth) : 1;
   localparam logic [CntW:0]      DepthW    = (CntW + 1)'(RspDepth);
   localparam logic [CntW-1:0]    FullCnt   = CntW'(RspDepth);
   localparam logic [PtrW-1:0]    LastPtr   = PtrW'(RspDepth - 1);
   localparam logic [AddrWidth:0] NumWordsW = (AddrWidth + 1)'(NumWords);

   logic                 rd_accept;
   logic                 fifo_push;
   logic                 fifo_pop;
   logic                 credit_ok;
   logic [CntW-1:0]      inflight_cnt;
   logic [CntW:0]        used_after_pop;
   logic [CntW-1:0]      fifo_cnt_q, fifo_cnt_d;
   logic [PtrW-1:0]      wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0]      rd_ptr_q, rd_ptr_d;
   logic [DataWidth-1:0] fifo_mem_q [RspDepth];

   // A read needs a free slot counting everything in flight; a same-cycle pop frees one.
   assign fifo_pop       = rsp_valid_o & rsp_ready_i;
   assign used_after_pop = {1'b0, inflight_cnt} + {1'b0, fifo_cnt_q}
                         - {{CntW{1'b0}}, fifo_pop};
   assign credit_ok      = used_after_pop < DepthW;
   assign req_ready_o    = req_we_i | credit_ok;
   assign mem_req_o      = req_valid_i & req_ready_o;
   assign rd_accept      = mem_req_o & ~req_we_i;

   assign mem_we_o    = req_we_i;
   assign mem_addr_o  = req_addr_i;
   assign mem_wdata_o = req_wdata_i;
   assign mem_be_o    = req_be_i;

   if (Latency == 0) begin : g_lat0
      assign fifo_push    = rd_accept;
      assign inflight_cnt = '0;
   end else begin : g_lat
      logic [Latency-1:0] pipe_q, pipe_d;
      logic [CntW-1:0]    infl_q, infl_d;

      always_comb begin
         pipe_d            = pipe_q >> 1;
         pipe_d[Latency-1] = rd_accept;
         infl_d            = infl_q + CntW'(rd_accept) - CntW'(pipe_q[0]);
      end

      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            pipe_q <= '0;
            infl_q <= '0;
         end else begin
            pipe_q <= pipe_d;
            infl_q <= infl_d;
         end
      end

      assign fifo_push    = pipe_q[0];
      assign inflight_cnt = infl_q;
   end

   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      fifo_cnt_d = fifo_cnt_q;
      if (fifo_push) begin
         wr_ptr_d = (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + 1'b1;
      end
      if (fifo_pop) begin
         rd_ptr_d = (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + 1'b1;
      end
      case ({fifo_push, fifo_pop})
         2'b10:   fifo_cnt_d = fifo_cnt_q + 1'b1;
         2'b01:   fifo_cnt_d = fifo_cnt_q - 1'b1;
         default: fifo_cnt_d = fifo_cnt_q;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         fifo_cnt_q <= '0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         fifo_cnt_q <= fifo_cnt_d;
      end
   end

   // Storage needs no reset: nothing reads it until a push has written the entry.
   always_ff @(posedge clk_i) begin
      if (fifo_push) begin
         fifo_mem_q[wr_ptr_q] <= mem_rdata_i;
      end
   end

   assign rsp_valid_o = (fifo_cnt_q != '0);
   assign rsp_rdata_o = fifo_mem_q[rd_ptr_q];

   a_addr_range: assert property (@(posedge clk_i) disable iff (!rst_ni)
      mem_req_o |-> ({1'b0, req_addr_i} < NumWordsW));
   a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
      (fifo_push && !fifo_pop) |-> (fifo_cnt_q != FullCnt));
   a_no_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
      fifo_pop |-> (fifo_cnt_q != '0));
   a_credit_bound: assert property (@(posedge clk_i) disable iff (!rst_ni)
      ({1'b0, inflight_cnt} + {1'b0, fifo_cnt_q}) <= DepthW);

endmodule

// File: tb/tb_tc_sram_initiator.sv
// Bench for tc_sram_initiator: two configurations (Latency=1/RspDepth=2 and Latency=0/RspDepth=1)
// against a memory stub and a queue-based reference of the request/response rules.
module tb_tc_sram_initiator;

   localparam int NW = 64;
   localparam int DW = 32;
   localparam int BW = 4;
   localparam int AW = 6;

   logic clk = 1'b0;
   int   cyc = 0;
   int   n_checks = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h at cycle %0d", tag, got, exp, cyc);
      end
   endtask

   for (genvar gi = 0; gi < 2; gi++) begin : g_cfg
      localparam int L = (gi == 0) ? 1 : 0;
      localparam int D = (gi == 0) ? 2 : 1;

      typedef struct {
         logic [DW-1:0] data;
         int            due;
      } exp_t;

      logic          rst_n, tb_init, done;
      logic          req_valid, req_ready, req_we, rsp_valid, rsp_ready;
      logic [AW-1:0] req_addr, mem_addr;
      logic [DW-1:0] req_wdata, rsp_rdata, mem_wdata, mem_rdata, rdata_reg;
      logic [BW-1:0] req_be, mem_be;
      logic          mem_req, mem_we;
      logic [DW-1:0] mem [NW];
      logic [DW-1:0] gold [NW];
      exp_t          exp_q [$];

      tc_sram_initiator #(
         .NumWords(NW), .DataWidth(DW), .ByteWidth(8), .Latency(L), .RspDepth(D)
      ) dut (
         .clk_i(clk), .rst_ni(rst_n),
         .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
         .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_be_i(req_be),
         .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata),
         .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
         .mem_wdata_o(mem_wdata), .mem_be_o(mem_be), .mem_rdata_i(mem_rdata)
      );

      // Memory stub with the configured read latency
      always @(posedge clk) begin
         if (tb_init) begin
            for (int i = 0; i < NW; i++) mem[i] <= '0;
         end else if (mem_req) begin
            if (mem_we) begin
               for (int b = 0; b < BW; b++)
                  if (mem_be[b]) mem[mem_addr][b*8 +: 8] <= mem_wdata[b*8 +: 8];
            end else begin
               rdata_reg <= mem[mem_addr];
            end
         end
      end
      assign mem_rdata = (L == 0) ? mem[mem_addr] : rdata_reg;

      // Reference: every accepted read owes one response, in order, no earlier than t+L+1
      always @(negedge clk) begin
         if (!rst_n || tb_init) begin
            exp_q.delete();
            if (tb_init) for (int i = 0; i < NW; i++) gold[i] = '0;
            check($sformatf("c%0d_rst_rsp_valid", gi), 64'(rsp_valid), 64'd0);
         end else begin
            logic exp_valid, pop, exp_ready, accept;
            int   outstanding;
            exp_valid = (exp_q.size() > 0) && (exp_q[0].due <= cyc);
            check($sformatf("c%0d_rsp_valid", gi), 64'(rsp_valid), 64'(exp_valid));
            if (exp_valid)
               check($sformatf("c%0d_rsp_rdata", gi), 64'(rsp_rdata), 64'(exp_q[0].data));
            pop         = exp_valid && rsp_ready;
            outstanding = exp_q.size() - (pop ? 1 : 0);
            exp_ready   = req_we || (outstanding < D);
            if (req_valid)
               check($sformatf("c%0d_req_ready", gi), 64'(req_ready), 64'(exp_ready));
            accept = req_valid && exp_ready;
            check($sformatf("c%0d_mem_req", gi), 64'(mem_req), 64'(accept));
            if (accept) begin
               check($sformatf("c%0d_mem_addr", gi), 64'(mem_addr), 64'(req_addr));
               check($sformatf("c%0d_mem_we", gi), 64'(mem_we), 64'(req_we));
            end
            if (pop) void'(exp_q.pop_front());
            if (accept) begin
               if (req_we) begin
                  for (int b = 0; b < BW; b++)
                     if (req_be[b]) gold[req_addr][b*8 +: 8] = req_wdata[b*8 +: 8];
               end else begin
                  exp_q.push_back('{data: gold[req_addr], due: cyc + L + 1});
               end
            end
         end
      end

      task automatic drive(input logic v, input logic we, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input logic [BW-1:0] be, input logic rr);
         req_valid = v;
         req_we    = we;
         req_addr  = a;
         req_wdata = d;
         req_be    = be;
         rsp_ready = rr;
         @(posedge clk);
         #1;
      endtask

      initial begin
         done = 1'b0; rst_n = 1'b0; tb_init = 1'b1;
         req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0;
         rsp_ready = 1'b0;
         repeat (3) @(posedge clk);
         #1;
         tb_init = 1'b0;
         rst_n   = 1'b1;
         if (gi == 0) begin
            drive(1, 1, 6'h10, 32'hA5A5_A5A5, 4'hF, 1);
            drive(1, 0, 6'h10, '0, '0, 1);
            repeat (3) drive(0, 0, '0, '0, '0, 1);
            for (int i = 0; i < 4; i++) drive(1, 0, AW'(i), '0, '0, 1);
            repeat (4) drive(0, 0, '0, '0, '0, 1);
            drive(1, 0, 6'h1, '0, '0, 0);
            drive(1, 0, 6'h2, '0, '0, 0);
            repeat (3) drive(1, 0, 6'h3, '0, '0, 0);
            drive(1, 0, 6'h3, '0, '0, 1);
            repeat (4) drive(0, 0, '0, '0, '0, 1);
            drive(1, 1, 6'h20, 32'hFFFF_FFFF, 4'hF, 1);
            drive(1, 1, 6'h20, 32'h0, 4'h1, 1);
            drive(1, 0, 6'h20, '0, '0, 1);
            repeat (3) drive(0, 0, '0, '0, '0, 1);
            drive(1, 0, 6'h10, '0, '0, 1);
            drive(1, 0, 6'h20, '0, '0, 1);
            req_valid = 1'b0;
            rst_n     = 1'b0;
            repeat (2) drive(0, 0, '0, '0, '0, 1);
            rst_n = 1'b1;
            repeat (4) drive(0, 0, '0, '0, '0, 1);
         end else begin
            drive(1, 1, 6'h05, 32'h1234_5678, 4'hF, 1);
            for (int i = 0; i < 8; i++) drive(1, 0, AW'(i), '0, '0, 1);
            repeat (3) drive(0, 0, '0, '0, '0, 1);
         end
         for (int k = 0; k < 400; k++) begin
            drive($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 4,
                  AW'($urandom_range(0, 15)), DW'($urandom), BW'($urandom),
                  $urandom_range(0, 9) < 6);
         end
         repeat (10) drive(0, 0, '0, '0, '0, 1);
         done = 1'b1;
      end
   end

   initial begin
      int waited;
      waited = 0;
      while (!(g_cfg[0].done && g_cfg[1].done) && waited < 20000) begin
         @(posedge clk);
         waited++;
      end
      check("stimulus_done", 64'(g_cfg[0].done & g_cfg[1].done), 64'd1);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
